// File: rtl/seg_scan_hex_if.sv
// seg_scan_hex_if: core-side inputs and display-pin outputs of the scanned hex display driver.
interface seg_scan_hex_if #(parameter int DIGITS = 8);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     digit_en;
    logic [DIGITS-1:0]     dp;
    logic [7:0]            seg_out;
    logic [DIGITS-1:0]     an_out;
    logic                  scan_done;
    modport master (output en, load, value, digit_en, dp, input seg_out, an_out, scan_done);
    modport slave  (input en, load, value, digit_en, dp, output seg_out, an_out, scan_done);
endinterface

// File: rtl/seg_scan_hex.sv
// seg_scan_hex: time-multiplexed common-anode hex display driver with frame-synchronous updates.
// Define SEG_SCAN_LZ_BLANK_EN to blank leading-zero digits.
module seg_scan_hex #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000
) (
    input logic          clk,
    input logic          rst,
    seg_scan_hex_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam logic [7:0] GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    logic [DW-1:0]     div_q, div_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [VW-1:0]     sh_val_q, sh_val_d, dv_q, dv_d;
    logic [DIGITS-1:0] sh_en_q, sh_en_d, sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0] de_q, de_d, dd_q, dd_d, an_q, an_d;
    logic [7:0]        seg_q, seg_d, glyph;
    logic [3:0]        nib;
    logic              div_wrap, idx_last, done, en_sel, dp_sel, lz_sel, show;

    always_comb begin
        div_wrap = div_q == DW'(SCAN_DIV - 1);
        idx_last = idx_q == IW'(DIGITS - 1);
        done     = div_wrap && idx_last;
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        idx_d    = !div_wrap ? idx_q : idx_last ? '0 : idx_q + 1'b1;
        sh_val_d = bus.load ? bus.value    : sh_val_q;
        sh_en_d  = bus.load ? bus.digit_en : sh_en_q;
        sh_dp_d  = bus.load ? bus.dp       : sh_dp_q;
        pend_d   = !done && (bus.load || pend_q);
        // A load landing on the boundary bypasses the shadow so it is not delayed a frame.
        dv_d     = done && bus.load ? bus.value    : done && pend_q ? sh_val_q : dv_q;
        de_d     = done && bus.load ? bus.digit_en : done && pend_q ? sh_en_q  : de_q;
        dd_d     = done && bus.load ? bus.dp       : done && pend_q ? sh_dp_q  : dd_q;
        nib      = '0;
        en_sel   = 1'b0;
        dp_sel   = 1'b0;
        lz_sel   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib    = dv_q[4*i +: 4];
                en_sel = de_q[i];
                dp_sel = dd_q[i];
`ifdef SEG_SCAN_LZ_BLANK_EN
                lz_sel = (i > 0) && ((dv_q >> (4*i)) == '0);
`endif
            end
        end
        glyph = GLYPH[nib];
        show  = bus.en && en_sel && !lz_sel;
        seg_d = show ? {glyph[7:1], glyph[0] & ~dp_sel} : 8'hFF;
        an_d  = show ? ~(DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            sh_val_q <= '0;
            sh_en_q  <= '0;
            sh_dp_q  <= '0;
            dv_q     <= '0;
            de_q     <= '0;
            dd_q     <= '0;
            seg_q    <= 8'hFF;
            an_q     <= '1;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            sh_val_q <= sh_val_d;
            sh_en_q  <= sh_en_d;
            sh_dp_q  <= sh_dp_d;
            dv_q     <= dv_d;
            de_q     <= de_d;
            dd_q     <= dd_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign bus.seg_out   = seg_q;
    assign bus.an_out    = an_q;
    assign bus.scan_done = done;
endmodule

// File: doc/seg_scan_hex.md
Name: seg_scan_hex

Overview:
- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display bank. It is the parametrised successor to the single-digit hex decoder.
- Accepts a packed hex value, per-digit enable mask and decimal-point mask.
- Scans one digit at a time, producing a shared active-low segment bus and active-low digit selects.
- Sits between core status/debug registers and board display pins. Display updates are frame-synchronous, so no tearing occurs.

Parameters:
- DIGITS, 8, number of digits scanned (legal range 1..16).
- SCAN_DIV, 1000, clock cycles each digit is held active (legal minimum 2).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  global display enable; 0 blanks the display.
- load  input  1  strobe: capture value/digit_en/dp into shadow registers.
- value  input  4*DIGITS  packed nibbles; digit i = value[4i+3:4i]; digit 0 is least significant.
- digit_en  input  DIGITS  per-digit enable; 0 forces that digit blank.
- dp  input  DIGITS  per-digit decimal point; 1 lights the dp.
- seg_out  output  8  active-low segments: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- an_out  output  DIGITS  active-low digit select; at most one bit low.
- scan_done  output  1  one-cycle pulse on the last cycle of each full frame.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - div=0, idx=0, pending=0;
  - shadow and display registers all 0, digit_en=0, dp=0;
  - seg_out=8'hFF, an_out=all ones, scan_done=0.
- rst overrides every other input. Reset mid-frame aborts the frame, and scanning restarts from digit 0.
- Divider:
  - div counts 0..SCAN_DIV-1, then wraps to 0.
  - On each wrap, idx advances 0..DIGITS-1, then wraps to 0.
  - With DIGITS=1, idx stays 0.
- scan_done=1 for exactly the cycle in which div==SCAN_DIV-1 and idx==DIGITS-1. Frame period is DIGITS*SCAN_DIV cycles.
- Load:
  - load=1 captures value, digit_en and dp into shadow and sets pending=1. Repeated loads overwrite the shadow; the last one wins.
  - Display registers copy from shadow only at a frame boundary (the scan_done cycle) with pending=1; pending then clears.
  - If load and the boundary fall in the same cycle, the display takes the incoming inputs directly and pending stays 0.
- Glyph table, active-low, dp bit=1, values 0..F in order:
  - 03 9F 25 0D 99 49 41 1F 01 09 11 C1 63 85 61 71.
  - If dp[idx]=1, bit0 is forced to 0.
- Outputs are registered and reflect idx/display with 1-cycle latency. With digit k selected in cycle t, the outputs in cycle t+1 are:
  - en=1 and digit_en[k]=1: an_out = ~(1<<k), seg_out = glyph(nibble k) with dp applied.
  - en=0 or digit_en[k]=0: an_out = all ones, seg_out = 8'hFF.
- Counters run regardless of en. Toggling en never resets the scan position.
- Because the outputs lag idx by one cycle, the first digit after the frame boundary shows the new display contents.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - Digit k>0 is blanked (seg_out=FF, an_out all ones) when nibbles k..DIGITS-1 of the display register are all zero.
  - Digit 0 is never blanked by this rule.
  - A set dp on a blanked digit is still suppressed.
  - The blank mask is computed combinationally from the display register, so it has no additional latency.
- Undefined: zeros display as glyph 03; behaviour is otherwise identical.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset, then hold rst=0 with en=1 for 20 cycles, no load -> digit_en=0, so seg_out=FF and an_out=F throughout. scan_done pulses at cycles 16 and 32 after reset release, then every 16 cycles.
- load value=16'h12AF, digit_en=F, dp=0 -> at the next boundary+1, the anodes sequence E,D,B,7 (4 cycles each) with seg_out 71,11,25,9F respectively.
- Mid-frame load of 16'h0000 while 16'h12AF is shown -> the remaining digits of that frame still show 12AF; the next frame shows 03 on all four digits (macro undefined).
- load asserted in the scan_done cycle with value 16'h8888, dp=4'b0010 -> the next frame shows 01 on digits 0, 2, 3 and 00 on digit 1.
- en=0 for one full frame, then en=1 -> outputs are FF/F while en=0. After re-enable, the digit shown matches the free-running idx, with no restart at digit 0.
- SEG_SCAN_LZ_BLANK_EN defined, value 16'h0050 -> digits 3 and 2 show FF/anode high; digit 1 shows 49; digit 0 shows 03. With value 16'h0000, only digit 0 shows 03.
